pc_sequencer: RTL

- Program sequencer sitting directly upstream of the control ROM in cpu_controller.
- Generates the ROM address stream and an `issue` qualifier that downstream logic ANDs with the ROM `load` bit.
- Supports free-run, single-step, abort and end-of-program handling, and counts issued instructions.

---
 rtl/pc_sequencer_pkg.sv | 16 +
 rtl/pc_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program sequencer.
package seq_pkg;

    // Sequencer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    // Issued-instruction counter width and saturation value.
    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'd255;

endpackage

// File: rtl/pc_sequencer.sv
// Program sequencer feeding the control ROM: produces the ROM address stream,
// a zero-latency issue qualifier and a saturating issued-instruction count.
// Optional build macro SEQ_OVF_HALT_EN: an issued instruction with ovf_flag
// set ends the program in DONE with ovf_halt raised.
module pc_sequencer
    import seq_pkg::*;
#(
    parameter int ADDR_W    = 3,
    parameter int LAST_ADDR = 6,
    parameter int LOOP      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              step_mode,
    input  logic              step,
    input  logic              ovf_flag,
    output logic [ADDR_W-1:0] addr,
    output logic              issue,
    output logic              busy,
    output logic              done,
    output logic              ovf_halt,
    output logic [CNT_W-1:0]  instr_cnt
);

    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(LAST_ADDR);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_done;
    logic               r_ovf_halt;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               w_done_nxt;
    logic               w_ovf_halt_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_issue;
    logic               w_ovf_hit;

`ifdef SEQ_OVF_HALT_EN
    assign w_ovf_hit = ovf_flag;
`else
    // Overflow halting is compiled out; the flag has no effect.
    logic w_unused_ovf;
    assign w_unused_ovf = ovf_flag;
    assign w_ovf_hit    = 1'b0;
`endif

    // Next-state, next-datapath and issue decode; everything holds by default.
    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_done_nxt     = r_done;
        w_ovf_halt_nxt = r_ovf_halt;
        w_cnt_nxt      = r_cnt;
        w_issue        = ~stop & ((r_state == RUN) | ((r_state == STEP) & step));

        case (r_state)
            IDLE, DONE: begin
                // stop outranks start, so start+stop leaves everything as is.
                if (start && !stop) begin
                    w_addr_nxt     = '0;
                    w_cnt_nxt      = '0;
                    w_done_nxt     = 1'b0;
                    w_ovf_halt_nxt = 1'b0;
                    w_state_nxt    = step_mode ? STEP : RUN;
                end
            end
            RUN, STEP: begin
                if (stop) begin
                    // Abort: the count is kept for inspection, address rewinds.
                    w_state_nxt = IDLE;
                    w_addr_nxt  = '0;
                    w_done_nxt  = 1'b0;
                end else if (w_issue) begin
                    w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
                    if (w_ovf_hit) begin
                        // Overflow halt wins over the loop wrap; addr stays put.
                        w_state_nxt    = DONE;
                        w_done_nxt     = 1'b1;
                        w_ovf_halt_nxt = 1'b1;
                    end else if (r_addr != LAST_A) begin
                        w_addr_nxt = r_addr + ADDR_W'(1);
                    end else if (LOOP != 0) begin
                        w_addr_nxt = '0;
                    end else begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_addr     <= '0;
            r_done     <= 1'b0;
            r_ovf_halt <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_done     <= w_done_nxt;
            r_ovf_halt <= w_ovf_halt_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    assign addr      = r_addr;
    assign issue     = w_issue;
    assign busy      = (r_state == RUN) | (r_state == STEP);
    assign done      = r_done;
    assign ovf_halt  = r_ovf_halt;
    assign instr_cnt = r_cnt;

endmodule
